// File: rtl/regfile_onehot_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_onehot_sb_pkg
// Shared CPU definitions used by the register file and its one-hot encoder.
//   DATA_W    : architectural register width
//   REG_NUM   : number of architectural registers (one-hot vector width)
//   ADDR_W    : register index width, log2(REG_NUM)
//   reg_idx_t : register index type
//   ZERO_REG  : hard-wired zero register index
// ---------------------------------------------------------------------------
package regfile_onehot_sb_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_onehot_sb_onehot_encoder.sv
// ---------------------------------------------------------------------------
// onehot_encoder
// Purely combinational classifier/encoder for a one-hot select vector.
// Ports:
//   vec       in  N-bit select vector
//   idx       out position of the set bit (meaningful only when is_onehot)
//   is_onehot out exactly one bit set
//   is_zero   out no bit set
//   multi     out two or more bits set (malformed)
// ---------------------------------------------------------------------------
module onehot_encoder
  import regfile_onehot_sb_pkg::*;
#(
  parameter int N = REG_NUM,
  parameter int W = ADDR_W
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         is_onehot,
  output logic         is_zero,
  output logic         multi
);

  logic at_most_one;

  // Clearing the lowest set bit leaves zero only if at most one bit was set.
  assign is_zero     = (vec == '0);
  assign at_most_one = ((vec & (vec - N'(1))) == '0);
  assign is_onehot   = at_most_one && !is_zero;
  assign multi       = !at_most_one;

  // OR-ing positions of set bits gives the exact index for a one-hot input.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = idx | W'(i);
    end
  end

endmodule

// File: rtl/regfile_onehot_sb.sv
// ---------------------------------------------------------------------------
// regfile_onehot_sb
// 32x32 register file with one-hot write select, two combinational read
// ports with same-cycle write-through bypass, and a pending-write scoreboard.
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   we_onehot      one-hot write select (enable folded in), 0 = no write
//   wdata          write-back data
//   issue_onehot   one-hot "destination outstanding" mark, 0 = none
//   raddr1/raddr2  read addresses
//   rdata1/rdata2  combinational read data (register 0 reads as 0)
//   busy1/busy2    source not yet available (stall)
//   pend_cnt       registered count of pending registers
//   onehot_err     sticky flag for malformed one-hot vectors
// ---------------------------------------------------------------------------
module regfile_onehot_sb
#(
  parameter int DATA_W  = regfile_onehot_sb_pkg::DATA_W,
  parameter int REG_NUM = regfile_onehot_sb_pkg::REG_NUM,
  parameter int ADDR_W  = regfile_onehot_sb_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_NUM-1:0] we_onehot,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [REG_NUM-1:0] issue_onehot,
  input  logic [ADDR_W-1:0]  raddr1,
  input  logic [ADDR_W-1:0]  raddr2,
  output logic [DATA_W-1:0]  rdata1,
  output logic [DATA_W-1:0]  rdata2,
  output logic               busy1,
  output logic               busy2,
  output logic [ADDR_W:0]    pend_cnt,
  output logic               onehot_err
);

  import regfile_onehot_sb_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]  regs [REG_NUM];
  logic [REG_NUM-1:0] pending;

  logic [ADDR_W-1:0]  w_idx, i_idx;
  logic               w_onehot, w_zero, w_multi;
  logic               i_onehot, i_zero, i_multi;
  logic               wvalid, ivalid;
  logic               unused_zero;
  logic [REG_NUM-1:0] set_vec, clr_vec;
  logic               cnt_inc, cnt_dec;

  onehot_encoder #(.N(REG_NUM), .W(ADDR_W)) u_wenc (
    .vec       (we_onehot),
    .idx       (w_idx),
    .is_onehot (w_onehot),
    .is_zero   (w_zero),
    .multi     (w_multi)
  );

  onehot_encoder #(.N(REG_NUM), .W(ADDR_W)) u_ienc (
    .vec       (issue_onehot),
    .idx       (i_idx),
    .is_onehot (i_onehot),
    .is_zero   (i_zero),
    .multi     (i_multi)
  );

  // Emptiness alone carries no action here; multi/is_onehot decide everything.
  assign unused_zero = w_zero ^ i_zero;

  // A select of register 0 alone is a silent no-op.
  assign wvalid = w_onehot && (w_idx != ZERO_IDX);
  assign ivalid = i_onehot && (i_idx != ZERO_IDX);

  assign clr_vec = wvalid ? (REG_NUM'(1) << w_idx) : '0;
  assign set_vec = ivalid ? (REG_NUM'(1) << i_idx) : '0;

  // Counter tracks popcount(pending) incrementally. A write that lands on the
  // index being re-issued in the same cycle does not clear, so no decrement.
  assign cnt_inc = ivalid && !pending[i_idx];
  assign cnt_dec = wvalid && pending[w_idx] && !(ivalid && (i_idx == w_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      pending    <= '0;
      pend_cnt   <= '0;
      onehot_err <= 1'b0;
    end else begin
      if (wvalid) regs[w_idx] <= wdata;
      // Set after clear so a new producer wins over the completing one.
      pending    <= (pending & ~clr_vec) | set_vec;
      pend_cnt   <= pend_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
      onehot_err <= onehot_err | w_multi | i_multi;
    end
  end

  // Read ports: zero register first, then bypass of this cycle's write.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == ZERO_IDX) rdata1 = '0;
    else if (wvalid && (w_idx == raddr1)) rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == ZERO_IDX) rdata2 = '0;
    else if (wvalid && (w_idx == raddr2)) rdata2 = wdata;
  end

  // Bypassed data is usable, so a matching write this cycle lifts the stall.
  assign busy1 = (raddr1 != ZERO_IDX) && pending[raddr1] && !(wvalid && (w_idx == raddr1));
  assign busy2 = (raddr2 != ZERO_IDX) && pending[raddr2] && !(wvalid && (w_idx == raddr2));

endmodule

// File: tb/tb_regfile_onehot_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_onehot_sb
// Directed stimulus with hand-computed expectations pushed into a queue; a
// monitor process pops and compares against the DUT outputs each falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_onehot_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] we_onehot = '0;
  logic [31:0] wdata = '0;
  logic [31:0] issue_onehot = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2;
  logic [5:0]  pend_cnt;
  logic        onehot_err;

  int testsRun = 0;
  int testsFailed = 0;

  typedef enum int {SEL_RD1, SEL_RD2, SEL_BUSY1, SEL_BUSY2, SEL_PCNT, SEL_ERR} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } expect_t;

  expect_t sbQueue [$];

  regfile_onehot_sb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_onehot    (we_onehot),
    .wdata        (wdata),
    .issue_onehot (issue_onehot),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .busy1        (busy1),
    .busy2        (busy2),
    .pend_cnt     (pend_cnt),
    .onehot_err   (onehot_err)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input logic [31:0] we, input logic [31:0] wd,
                               input logic [31:0] iss, input logic [4:0] ra1,
                               input logic [4:0] ra2);
    @(posedge clk);
    #1;
    we_onehot    = we;
    wdata        = wd;
    issue_onehot = iss;
    raddr1       = ra1;
    raddr2       = ra2;
  endtask

  // Queue an expectation for the monitor to check at the next falling edge.
  task automatic checkOutput(input string name, input sel_e sel, input logic [31:0] exp);
    expect_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sbQueue.push_back(e);
  endtask

  function automatic logic [31:0] pickActual(input sel_e sel);
    case (sel)
      SEL_RD1:   return rdata1;
      SEL_RD2:   return rdata2;
      SEL_BUSY1: return {31'b0, busy1};
      SEL_BUSY2: return {31'b0, busy2};
      SEL_PCNT:  return {26'b0, pend_cnt};
      default:   return {31'b0, onehot_err};
    endcase
  endfunction

  // Monitor: drain all queued expectations on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sbQueue.size() > 0) begin
        expect_t e;
        logic [31:0] act;
        e = sbQueue.pop_front();
        act = pickActual(e.sel);
        testsRun++;
        if (act !== e.exp) begin
          testsFailed++;
          $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    // Mid-cycle reset pulse, released between edges.
    #12 rst_n = 1'b0;
    #15 rst_n = 1'b1;

    applyStimulus(32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    checkOutput("reset_rd1", SEL_RD1, 32'h0);
    checkOutput("reset_rd2", SEL_RD2, 32'h0);
    checkOutput("reset_busy1", SEL_BUSY1, 32'h0);
    checkOutput("reset_busy2", SEL_BUSY2, 32'h0);
    checkOutput("reset_pcnt", SEL_PCNT, 32'h0);
    checkOutput("reset_err", SEL_ERR, 32'h0);

    // Write reg5 with bypass, then read back from storage.
    applyStimulus(32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd0);
    checkOutput("bypass_rd1", SEL_RD1, 32'hDEAD_BEEF);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
    checkOutput("stored_rd1", SEL_RD1, 32'hDEAD_BEEF);

    // Register 0 write is dropped silently.
    applyStimulus(32'h0000_0001, 32'h0000_1234, 32'h0, 5'd0, 5'd5);
    checkOutput("zero_rd1", SEL_RD1, 32'h0);
    checkOutput("zero_rd2_nobypass", SEL_RD2, 32'hDEAD_BEEF);
    checkOutput("zero_err", SEL_ERR, 32'h0);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    checkOutput("zero_rd1_after", SEL_RD1, 32'h0);
    checkOutput("zero_err_after", SEL_ERR, 32'h0);

    // Seed reg4, then a malformed two-bit write must touch neither reg4 nor reg5.
    applyStimulus(32'h0000_0010, 32'h4444_4444, 32'h0, 5'd4, 5'd0);
    checkOutput("w4_bypass", SEL_RD1, 32'h4444_4444);
    applyStimulus(32'h0000_0030, 32'hFFFF_FFFF, 32'h0, 5'd4, 5'd5);
    checkOutput("multi_rd1_nobypass", SEL_RD1, 32'h4444_4444);
    checkOutput("multi_rd2_nobypass", SEL_RD2, 32'hDEAD_BEEF);
    checkOutput("multi_err_before", SEL_ERR, 32'h0);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd4, 5'd5);
    checkOutput("multi_reg4", SEL_RD1, 32'h4444_4444);
    checkOutput("multi_reg5", SEL_RD2, 32'hDEAD_BEEF);
    checkOutput("multi_err", SEL_ERR, 32'h1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("err_sticky", SEL_ERR, 32'h1);
    end

    // Scoreboard: issue reg8, then write it back.
    applyStimulus(32'h0, 32'h0, 32'h0000_0100, 5'd0, 5'd8);
    checkOutput("issue_busy2_same", SEL_BUSY2, 32'h0);
    checkOutput("issue_pcnt_same", SEL_PCNT, 32'h0);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd8);
    checkOutput("issue_busy2", SEL_BUSY2, 32'h1);
    checkOutput("issue_pcnt", SEL_PCNT, 32'h1);
    applyStimulus(32'h0000_0100, 32'h0000_A5A5, 32'h0, 5'd0, 5'd8);
    checkOutput("wb_busy2_bypass", SEL_BUSY2, 32'h0);
    checkOutput("wb_rd2_bypass", SEL_RD2, 32'h0000_A5A5);
    checkOutput("wb_pcnt_same", SEL_PCNT, 32'h1);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd8);
    checkOutput("wb_busy2", SEL_BUSY2, 32'h0);
    checkOutput("wb_pcnt", SEL_PCNT, 32'h0);
    checkOutput("wb_rd2", SEL_RD2, 32'h0000_A5A5);

    // Re-pend reg8, then set and clear it in the same cycle.
    applyStimulus(32'h0, 32'h0, 32'h0000_0100, 5'd0, 5'd0);
    applyStimulus(32'h0000_0100, 32'h0000_0077, 32'h0000_0100, 5'd8, 5'd0);
    checkOutput("setclr_pcnt_before", SEL_PCNT, 32'h1);
    checkOutput("setclr_busy1_bypass", SEL_BUSY1, 32'h0);
    checkOutput("setclr_rd1_bypass", SEL_RD1, 32'h0000_0077);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
    checkOutput("setclr_rd1", SEL_RD1, 32'h0000_0077);
    checkOutput("setclr_busy1", SEL_BUSY1, 32'h1);
    checkOutput("setclr_pcnt", SEL_PCNT, 32'h1);

    // Bit-0-only issue is ignored; raddr 0 never busy.
    applyStimulus(32'h0, 32'h0, 32'h0000_0001, 5'd0, 5'd8);
    checkOutput("iss0_busy1", SEL_BUSY1, 32'h0);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd8);
    checkOutput("iss0_pcnt", SEL_PCNT, 32'h1);
    checkOutput("iss0_busy2", SEL_BUSY2, 32'h1);

    // Write to a non-pending register leaves the count alone.
    applyStimulus(32'h8000_0000, 32'h3131_3131, 32'h0, 5'd0, 5'd31);
    checkOutput("w31_rd2_bypass", SEL_RD2, 32'h3131_3131);
    checkOutput("w31_busy2", SEL_BUSY2, 32'h0);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 5'd31);
    checkOutput("w31_pcnt", SEL_PCNT, 32'h1);
    checkOutput("w31_rd2", SEL_RD2, 32'h3131_3131);

    // Issue reg31, then clear reg8 while re-issuing the already-pending reg31.
    applyStimulus(32'h0, 32'h0, 32'h8000_0000, 5'd0, 5'd0);
    applyStimulus(32'h0000_0100, 32'h0000_0088, 32'h8000_0000, 5'd8, 5'd31);
    checkOutput("two_pcnt_before", SEL_PCNT, 32'h2);
    checkOutput("two_busy1_bypass", SEL_BUSY1, 32'h0);
    checkOutput("two_busy2", SEL_BUSY2, 32'h1);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd8, 5'd31);
    checkOutput("two_pcnt_after", SEL_PCNT, 32'h1);
    checkOutput("two_busy1_after", SEL_BUSY1, 32'h0);
    checkOutput("two_busy2_after", SEL_BUSY2, 32'h1);
    checkOutput("two_rd1_after", SEL_RD1, 32'h0000_0088);

    // Reset mid-operation with a write in flight; the write must be lost.
    applyStimulus(32'h0000_0200, 32'h0000_0099, 32'h0, 5'd9, 5'd31);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_pcnt", SEL_PCNT, 32'h0);
    checkOutput("midrst_err", SEL_ERR, 32'h0);
    checkOutput("midrst_busy2", SEL_BUSY2, 32'h0);
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd9, 5'd31);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd9, 5'd31);
    checkOutput("midrst_reg9_lost", SEL_RD1, 32'h0);
    checkOutput("midrst_reg31", SEL_RD2, 32'h0);
    checkOutput("midrst_err_after", SEL_ERR, 32'h0);

    // Let the monitor drain, bounded to a couple of edges.
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    if (sbQueue.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", sbQueue.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/regfile_onehot_sb.md
Name: regfile_onehot_sb

Overview:
- 32x32 general-purpose register file for the CPU; sits directly downstream of the write-address decoder.
- Consumes the decoder's one-hot write vector, which already has the write enable folded in, and commits write-back data.
- Provides two combinational read ports with same-cycle write-through bypass.
- Keeps a pending-write scoreboard so decode can stall on registers whose multi-cycle producers (load, mult/div) have not written back yet.

Parameters:
- DATA_W, 32, register width in bits
- REG_NUM, 32, number of architectural registers; fixes the one-hot vector widths
- ADDR_W, 5, read address width; must equal log2(REG_NUM)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- we_onehot  in  REG_NUM  one-hot write select from the decoder; all-zero means no write
- wdata  in  DATA_W  write-back data
- issue_onehot  in  REG_NUM  one-hot "destination now outstanding" mark from issue; all-zero means none
- raddr1  in  ADDR_W  read port 1 address
- raddr2  in  ADDR_W  read port 2 address
- rdata1  out  DATA_W  read port 1 data, combinational
- rdata2  out  DATA_W  read port 2 data, combinational
- busy1  out  1  source 1 not yet available; stall
- busy2  out  1  source 2 not yet available; stall
- pend_cnt  out  ADDR_W+1  registered count of pending registers
- onehot_err  out  1  sticky flag: a malformed one-hot vector was received

Behaviour:
- Reset: rst_n low clears, asynchronously, all registers, all pending bits, pend_cnt and onehot_err to 0. Release is synchronous to clk in the surrounding design.
- Write validity:
  - wvalid = we_onehot has exactly one bit set AND that bit is not bit 0.
  - The written index is the position of that bit.
- Write commit: on the rising edge with wvalid, reg[idx] <= wdata.
  - Bit-0-only: silently dropped, no error.
  - Two or more bits set: no register is written and onehot_err <= 1.
- issue_onehot follows the same rules:
  - Exactly one bit set, not bit 0: pending[idx] <= 1.
  - Bit-0-only: ignored.
  - Two or more bits set: ignored and onehot_err <= 1.
- Read, zero latency:
  - rdataN = 0 if raddrN == 0.
  - Otherwise rdataN = wdata if wvalid and idx == raddrN (bypass).
  - Otherwise rdataN = reg[raddrN].
- Busy: busyN = pending[raddrN] AND NOT (wvalid AND idx == raddrN). Bypassed data is usable. busyN is always 0 for raddrN == 0.
- Scoreboard update each rising edge:
  - A valid write clears pending[idx].
  - A valid issue sets pending[issue_idx].
  - Same index in the same cycle: set wins. The write commits its data, but the register stays pending for the newer producer.
  - A write to a non-pending register is legal and leaves pending unchanged.
  - A re-issue to an already-pending register is legal; the bit stays at 1.
- pend_cnt: equals popcount(pending) after every edge; it is maintained incrementally.
  - +1 only on an issue to a not-pending register.
  - -1 only on a clearing write.
  - Set and clear on the same index: net 0 if that register was already pending, +1 if it was not.
  - Range is 0..31; it never wraps because bit 0 is never pending.
- onehot_err: remains 1 until reset.
- Reset mid-operation: all state clears immediately. An in-flight write in that cycle is lost.

Decomposition:
- Shared CPU package holds:
  - DATA_W, REG_NUM, ADDR_W
  - ZERO_REG = 0
  - a reg_idx_t typedef of ADDR_W bits
- One sub-module, onehot_encoder, instantiated twice (write path and issue path):
  - Input: REG_NUM-bit vector.
  - Outputs: idx (ADDR_W), is_onehot, is_zero, multi.
  - Purely combinational.
- The storage array, scoreboard and counter stay in regfile_onehot_sb.

Test Plan:
- Reset then reads: pulse rst_n low mid-cycle, then raddr1=5, raddr2=31 -> rdata1=rdata2=0, busy1=busy2=0, pend_cnt=0, onehot_err=0.
- Write and bypass:
  - we_onehot=0x0000_0020, wdata=0xDEADBEEF, raddr1=5 in the same cycle -> rdata1=0xDEADBEEF before the edge.
  - After the edge with we_onehot=0 -> rdata1 still 0xDEADBEEF.
- Zero register: we_onehot=0x0000_0001, wdata=0x1234 -> rdata1 at raddr1=0 is 0, onehot_err stays 0.
- Malformed vector:
  - we_onehot=0x0000_0030, wdata=0xFFFF_FFFF -> reg4 and reg5 unchanged, onehot_err=1.
  - onehot_err stays 1 for 10 cycles; only reset clears it.
- Scoreboard:
  - issue_onehot=0x0000_0100 -> next cycle raddr2=8 gives busy2=1, pend_cnt=1.
  - Write reg8 with 0xA5A5 -> busy2=0 in the write cycle, pend_cnt=0 after the edge.
- Simultaneous set and clear:
  - With reg8 pending, issue_onehot and we_onehot both 0x0000_0100, wdata=0x77 -> reg8=0x77, pending[8] stays 1, pend_cnt stays 1.
  - Next cycle, raddr1=8 -> busy1=1.
